// File: rtl/sequential_subtractor.sv
// Digit-serial subtractor: diff = x - y - b_in, one DIGIT-wide slice per cycle, LSB slice first.
// Define SEQ_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module sequential_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
`ifdef SEQ_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_sh, y_sh, acc, acc_nxt, dig_ext;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   slice;
  logic             last, accept;
`ifdef SEQ_SUB_OVERFLOW_EN
  logic             x_msb, y_msb;
`endif

  // Top bit of the (DIGIT+1)-bit difference is the borrow out of this slice.
  always_comb begin
    slice   = {1'b0, x_sh[DIGIT-1:0]} - {1'b0, y_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    dig_ext = WIDTH'(slice[DIGIT-1:0]);
    acc_nxt = (acc >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    last    = (cnt == CW'(N - 1));
    accept  = start && (state != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial slices collect in acc; diff/b_out only change on the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh   <= '0;
      y_sh   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      b_out  <= 1'b0;
`ifdef SEQ_SUB_OVERFLOW_EN
      x_msb  <= 1'b0;
      y_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      x_sh   <= x;
      y_sh   <= y;
      acc    <= '0;
      borrow <= b_in;
      cnt    <= '0;
`ifdef SEQ_SUB_OVERFLOW_EN
      x_msb  <= x[WIDTH-1];
      y_msb  <= y[WIDTH-1];
`endif
    end else if (state == RUN) begin
      x_sh   <= x_sh >> DIGIT;
      y_sh   <= y_sh >> DIGIT;
      acc    <= acc_nxt;
      borrow <= slice[DIGIT];
      if (!last) cnt <= cnt + CW'(1);
      if (last) begin
        diff  <= acc_nxt;
        b_out <= slice[DIGIT];
`ifdef SEQ_SUB_OVERFLOW_EN
        ovf   <= (x_msb ^ y_msb) & (acc_nxt[WIDTH-1] ^ x_msb);
`endif
      end
    end
  end
endmodule

// File: tb/tb_sequential_subtractor.sv
// Bench: five instances (DIGIT = 1,2,4,8,16) share stimulus; index 2 (DIGIT=4) is the directed target.
module tb_sequential_subtractor;
  localparam int W  = 16;
  localparam int NI = 5;
  localparam int D4 = 2;

  logic clk = 1'b0;
  logic rst, start, b_in;
  logic [W-1:0] x, y;
  logic [NI-1:0][W-1:0] diff_v;
  logic [NI-1:0] bo_v, busy_v, done_v;
`ifdef SEQ_SUB_OVERFLOW_EN
  logic [NI-1:0] ovf_v;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sequential_subtractor #(.WIDTH(W), .DIGIT(1 << g)) u_dut (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .b_in(b_in),
      .diff(diff_v[g]), .b_out(bo_v[g]),
`ifdef SEQ_SUB_OVERFLOW_EN
      .ovf(ovf_v[g]),
`endif
      .busy(busy_v[g]), .done(done_v[g]));
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, borrow, diff} from plain 17-bit arithmetic.
  function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] r;
    logic        o;
    r = {1'b0, a} - {1'b0, b} - 17'(bi);
    o = (a[15] != b[15]) && (r[15] != a[15]);
    return {o, r};
  endfunction

  typedef struct {
    logic [15:0] x, y;
    logic        b;
    logic [15:0] d;
    logic        bo, ov;
  } vec_t;

  // Waits for done on the DIGIT=4 instance; start is assumed accepted at the previous edge.
  task automatic wait_done(input int c0, input string nm, output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    for (int c = c0; c <= 12; c++) begin
      @(negedge clk);
      if (done_v[D4]) begin
        cyc = c;
        break;
      end
      if (busy_v[D4]) busy_n++;
    end
    if (cyc == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: done never seen within cycle budget", nm);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc, bn;
    @(posedge clk); #1;
    x = v.x; y = v.y; b_in = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~v.x; y = ~v.y; b_in = ~v.b;
    wait_done(1, nm, cyc, bn);
    chk({nm, " done cycle"}, cyc, 5);
    chk({nm, " busy cycles"}, bn, 4);
    chk({nm, " diff"}, diff_v[D4], v.d);
    chk({nm, " b_out"}, bo_v[D4], v.bo);
`ifdef SEQ_SUB_OVERFLOW_EN
    chk({nm, " ovf"}, ovf_v[D4], v.ov);
`endif
    @(negedge clk);
    chk({nm, " done one cycle"}, done_v[D4], 0);
  endtask

  vec_t tbl[7];
  logic [17:0] r;

  initial begin
    int cyc, bn, dn;
    int first[NI];
    int ndone[NI];
    logic [15:0] xr, yr;
    logic br;

    tbl[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[4] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    #12;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset D%0d diff", 1 << g), diff_v[g], 0);
      chk($sformatf("reset D%0d flags", 1 << g), {bo_v[g], busy_v[g], done_v[g]}, 0);
    end
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // start held high, operands changed mid-run, back-to-back restart from DONE
    @(posedge clk); #1;
    x = 16'h1234; y = 16'h0235; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    x = 16'hA5A5; y = 16'h1111; b_in = 1'b1;
    wait_done(2, "hold", cyc, bn);
    chk("hold done cycle", cyc, 5);
    chk("hold diff", diff_v[D4], 16'h0FFF);
    chk("hold b_out", bo_v[D4], 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b busy", busy_v[D4], 1);
    chk("b2b done low", done_v[D4], 0);
    wait_done(2, "b2b", cyc, bn);
    r = ref_sub(16'hA5A5, 16'h1111, 1'b1);
    chk("b2b done cycle", cyc, 5);
    chk("b2b diff", diff_v[D4], r[15:0]);
    chk("b2b b_out", bo_v[D4], r[16]);

    // reset in the 3rd RUN cycle
    @(posedge clk); #1;
    x = 16'h1234; y = 16'h0235; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-rst busy", busy_v[D4], 1);
    #1 rst = 1'b1;
    #1;
    chk("rst diff", diff_v[D4], 0);
    chk("rst flags", {bo_v[D4], busy_v[D4], done_v[D4]}, 0);
    @(negedge clk); rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_v[D4]) dn++;
    end
    chk("rst no done", dn, 0);
    run_vec('{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0}, "post-rst");

    repeat (20) @(posedge clk);

    // random sweep over all DIGIT values
    for (int k = 0; k < 1000; k++) begin
      xr = 16'($urandom); yr = 16'($urandom); br = 1'($urandom_range(0, 1));
      r = ref_sub(xr, yr, br);
      @(posedge clk); #1;
      x = xr; y = yr; b_in = br; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x = 16'($urandom); y = 16'($urandom); b_in = 1'($urandom_range(0, 1));
      for (int g = 0; g < NI; g++) begin first[g] = 0; ndone[g] = 0; end
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
          if (done_v[g]) begin
            ndone[g]++;
            if (first[g] == 0) begin
              first[g] = c;
              chk($sformatf("sweep%0d D%0d diff", k, 1 << g), diff_v[g], r[15:0]);
              chk($sformatf("sweep%0d D%0d b_out", k, 1 << g), bo_v[g], r[16]);
`ifdef SEQ_SUB_OVERFLOW_EN
              chk($sformatf("sweep%0d D%0d ovf", k, 1 << g), ovf_v[g], r[17]);
`endif
            end
          end
        end
      end
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("sweep%0d D%0d latency", k, 1 << g), first[g], (16 >> g) + 1);
        chk($sformatf("sweep%0d D%0d done count", k, 1 << g), ndone[g], 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
